// File: rtl/rx_arb_pkg.sv
// rx_arb_pkg: link direction codes, arbiter state type and link data width
package rx_arb_pkg;
  localparam int LINK_W = 16;
  localparam logic [1:0] DIR_E = 2'd0, DIR_S = 2'd1, DIR_W = 2'd2, DIR_N = 2'd3;
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: four-way round-robin pick, searching from last+1 upward
//   req[3:0] pending requesters, last[1:0] previous winner
//   any high when some req is set, winner[1:0] chosen index (only meaningful with any)
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] winner
);
  // Scan from lowest priority (last itself) up to last+1, so the final hit is the winner
  always_comb begin
    any = |req;
    winner = last;
    for (int k = 4; k >= 1; k--) if (req[last + 2'(k)]) winner = last + 2'(k);
  end
endmodule

// File: rtl/rx_rr_arbiter.sv
// rx_rr_arbiter: round-robin grant of the four mesh RX links onto one downstream 4-phase channel
//   rx_req_i/rx_data_i/rx_ack_o : per-link REQ, 16-bit data slice, ACK (index 0..3 = E,S,W,N)
//   RX_REQ/RX_DATA/RX_ACK       : downstream channel, forwarded with one register each way
//   pkt_done_i                  : packet-complete pulse from downstream
//   grant_dir_o/busy_o          : granted link and grant-active flag
//   timeout_o                   : one-cycle pulse on stall-forced release
module rx_rr_arbiter
  import rx_arb_pkg::*;
#(
  parameter int MAX_WORDS   = 256,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        rx_req_i,
  input  logic [63:0]       rx_data_i,
  output logic [3:0]        rx_ack_o,
  output logic              RX_REQ,
  output logic [LINK_W-1:0] RX_DATA,
  input  logic              RX_ACK,
  input  logic              pkt_done_i,
  output logic [1:0]        grant_dir_o,
  output logic              busy_o,
  output logic              timeout_o
);
  state_t r_state, w_next;
  logic [1:0] r_last, w_win;
  logic [15:0] r_cnt, w_cnt;
  logic [31:0] r_timer;
  logic [LINK_W-1:0] w_data;
  logic r_ack_d, w_any, w_act, w_req, w_chg, w_tmo, w_drained, w_fwd;
  rr_pick4 u_pick (.req(rx_req_i), .last(r_last), .any(w_any), .winner(w_win));
  assign w_act = r_state != IDLE;
  assign busy_o = w_act;
  assign w_req = rx_req_i[grant_dir_o];
  assign w_data = rx_data_i[{grant_dir_o, 4'd0} +: LINK_W];
  // While granted, RX_REQ holds last cycle's link REQ, so it serves as the change reference
  assign w_chg = (w_req != RX_REQ) || (RX_ACK != r_ack_d);
  assign w_tmo = w_act && !w_chg && r_timer == 32'(TIMEOUT_CYC - 1);
  assign w_cnt = (r_ack_d && !RX_ACK && r_cnt != 16'(MAX_WORDS)) ? r_cnt + 16'd1 : r_cnt;
  assign w_drained = !RX_REQ && !RX_ACK && !rx_ack_o[grant_dir_o];
  // Forwarding stops on the release cycle so a freshly raised REQ never leaks into IDLE
  assign w_fwd = w_act && w_next != IDLE;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_any ? GRANT : IDLE;
    else if (w_tmo) w_next = IDLE;
    else if (r_state == GRANT) w_next = (pkt_done_i || w_cnt == 16'(MAX_WORDS)) ? DRAIN : GRANT;
    else w_next = w_drained ? IDLE : DRAIN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_dir_o <= 2'd0;
      r_last <= DIR_S;
      RX_REQ <= 1'b0;
      RX_DATA <= '0;
      rx_ack_o <= 4'b0;
      r_cnt <= 16'd0;
      r_timer <= 32'd0;
      r_ack_d <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) grant_dir_o <= w_win;
      if (w_act && w_next == IDLE) r_last <= grant_dir_o;
      if (w_fwd) RX_DATA <= w_data;
      RX_REQ <= w_fwd && w_req;
      rx_ack_o <= w_fwd ? {3'b0, RX_ACK} << grant_dir_o : 4'b0;
      r_cnt <= w_fwd ? w_cnt : 16'd0;
      r_timer <= (w_fwd && !w_chg) ? r_timer + 32'd1 : 32'd0;
      r_ack_d <= RX_ACK;
      timeout_o <= w_tmo;
    end
  end
endmodule

// File: tb/tb_rx_rr_arbiter.sv
// tb_rx_rr_arbiter: randomized link/downstream agents with a round-robin grant model and per-link data scoreboard
module tb_rx_rr_arbiter;
  localparam int MW = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] rx_req_i = 4'b0;
  logic [63:0] rx_data_i = 64'b0;
  logic [3:0] rx_ack_o;
  logic RX_REQ;
  logic [15:0] RX_DATA;
  logic RX_ACK = 1'b0;
  logic pkt_done_i = 1'b0;
  logic [1:0] grant_dir_o;
  logic busy_o, timeout_o;
  rx_rr_arbiter #(.MAX_WORDS(MW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_req_i(rx_req_i), .rx_data_i(rx_data_i), .rx_ack_o(rx_ack_o),
    .RX_REQ(RX_REQ), .RX_DATA(RX_DATA), .RX_ACK(RX_ACK), .pkt_done_i(pkt_done_i),
    .grant_dir_o(grant_dir_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic [15:0] txw [4][64];
  int txh [4], txt [4], rxc [4];
  bit up_en [4];
  bit ds_en, auto_done, done_sent, prev_busy;
  int model_last, cur_g, tmo_cnt, cyc, ack_fall_cyc, idle_cyc;
  int gseq [$];
  int gwords [$];
  function automatic int rr_model(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction
  task automatic clear_bench();
    for (int i = 0; i < 4; i++) begin
      txh[i] = 0; txt[i] = 0; rxc[i] = 0; up_en[i] = 1;
    end
    rx_req_i = 4'b0; rx_data_i = 64'b0; RX_ACK = 1'b0; pkt_done_i = 1'b0;
    ds_en = 1; auto_done = 1; done_sent = 0; prev_busy = 0;
    model_last = 1; cur_g = 0; tmo_cnt = 0; ack_fall_cyc = 0; idle_cyc = 0;
    gseq.delete(); gwords.delete();
  endtask
  task automatic hold_reset();
    clear_bench();
    rst_n = 1'b0;
  endtask
  task automatic push(input int l, input logic [15:0] w);
    txw[l][txt[l]] = w;
    txt[l]++;
  endtask
  task automatic release_reset();
    for (int i = 0; i < 4; i++)
      if (txt[i] > 0) begin
        rx_data_i[16*i +: 16] = txw[i][0];
        rx_req_i[i] = 1'b1;
      end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic tick();
    int e;
    logic [3:0] mask;
    logic [15:0] want;
    @(negedge clk);
    cyc++;
    pkt_done_i = 1'b0;
    if (timeout_o) tmo_cnt++;
    if (busy_o && !prev_busy) begin
      e = rr_model(rx_req_i, model_last);
      tests++;
      if (e < 0 || grant_dir_o !== 2'(e)) begin
        fails++;
        $display("FAIL grant: got %0d expected %0d", grant_dir_o, e);
      end
      cur_g = int'(grant_dir_o);
      gseq.push_back(cur_g);
      gwords.push_back(0);
      done_sent = 0;
    end else if (busy_o) begin
      tests++;
      if (grant_dir_o !== 2'(cur_g)) begin
        fails++;
        $display("FAIL grant_hold: got %0d expected %0d", grant_dir_o, cur_g);
      end
    end
    if (!busy_o && prev_busy) begin
      model_last = cur_g;
      idle_cyc = cyc;
    end
    mask = busy_o ? 4'(1 << cur_g) : 4'b0;
    tests++;
    if ((rx_ack_o & ~mask) !== 4'b0) begin
      fails++;
      $display("FAIL ack_isolation: rx_ack_o=%b allowed=%b", rx_ack_o, mask);
    end
    if (RX_REQ && !RX_ACK && ds_en && $urandom_range(0, 3) != 0) begin
      want = rxc[cur_g] < txt[cur_g] ? txw[cur_g][rxc[cur_g]] : 16'hxxxx;
      tests++;
      if (!busy_o || rxc[cur_g] >= txt[cur_g] || RX_DATA !== want) begin
        fails++;
        $display("FAIL data link%0d: got %h expected %h", cur_g, RX_DATA, want);
      end
      if (rxc[cur_g] < txt[cur_g]) rxc[cur_g]++;
      if (gwords.size() > 0) gwords[gwords.size()-1] = gwords[gwords.size()-1] + 1;
      RX_ACK = 1'b1;
    end else if (!RX_REQ && RX_ACK && $urandom_range(0, 3) != 0) begin
      RX_ACK = 1'b0;
      ack_fall_cyc = cyc;
    end
    for (int i = 0; i < 4; i++)
      if (up_en[i]) begin
        if (rx_req_i[i] && rx_ack_o[i]) begin
          rx_req_i[i] = 1'b0;
          txh[i]++;
        end else if (!rx_req_i[i] && !rx_ack_o[i] && txh[i] < txt[i] && $urandom_range(0, 2) != 0) begin
          rx_data_i[16*i +: 16] = txw[i][txh[i]];
          rx_req_i[i] = 1'b1;
        end
      end
    if (auto_done && busy_o && !done_sent && txh[cur_g] == txt[cur_g] && !rx_req_i[cur_g] && !RX_ACK && !rx_ack_o[cur_g]) begin
      pkt_done_i = 1'b1;
      done_sent = 1;
    end
    prev_busy = busy_o;
  endtask
  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = !busy_o && !RX_ACK && rx_req_i == 4'b0;
      for (int i = 0; i < 4; i++) if (rxc[i] != txt[i]) done = 0;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s: not idle after %0d cycles (busy=%b)", name, n, busy_o);
    end
  endtask
  task automatic check_seq(input string name, input int exp_g [4], input int exp_w [4], input int len);
    tests++;
    if (gseq.size() != len) begin
      fails++;
      $display("FAIL %s_len: got %0d grants expected %0d", name, gseq.size(), len);
    end else
      for (int k = 0; k < len; k++) begin
        tests++;
        if (gseq[k] != exp_g[k] || (exp_w[k] >= 0 && gwords[k] != exp_w[k])) begin
          fails++;
          $display("FAIL %s[%0d]: got dir %0d/%0d words expected dir %0d/%0d words", name, k, gseq[k], gwords[k], exp_g[k], exp_w[k]);
        end
      end
  endtask
  task automatic test_reset();
    hold_reset();
    rx_req_i = 4'hF;
    rx_data_i = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    tests++;
    if (rx_ack_o !== 4'b0 || RX_REQ !== 1'b0) begin
      fails++;
      $display("FAIL reset_ack_req: rx_ack_o=%b RX_REQ=%b expected 0", rx_ack_o, RX_REQ);
    end
    tests++;
    if (RX_DATA !== 16'h0 || grant_dir_o !== 2'd0) begin
      fails++;
      $display("FAIL reset_data_dir: RX_DATA=%h grant=%0d expected 0", RX_DATA, grant_dir_o);
    end
    tests++;
    if (busy_o !== 1'b0 || timeout_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: busy=%b timeout=%b expected 0", busy_o, timeout_o);
    end
    rx_req_i = 4'b0;
    rst_n = 1'b1;
    tick();
    pkt_done_i = 1'b1;
    tick();
    tick();
    tests++;
    if (busy_o !== 1'b0 || RX_REQ !== 1'b0 || timeout_o !== 1'b0) begin
      fails++;
      $display("FAIL done_in_idle: busy=%b RX_REQ=%b timeout=%b expected 0", busy_o, RX_REQ, timeout_o);
    end
  endtask
  task automatic test_rr_order();
    int w [4];
    hold_reset();
    for (int i = 0; i < 4; i++) begin
      w[i] = 1 + $urandom_range(0, 2);
      for (int k = 0; k < w[i]; k++) push(i, 16'($urandom));
    end
    release_reset();
    run_until_idle("rr_order", 400);
    check_seq("rr_order", '{2, 3, 0, 1}, '{w[2], w[3], w[0], w[1]}, 4);
  endtask
  task automatic test_packet();
    int n = 0;
    bit sent = 0;
    hold_reset();
    push(2, 16'hA001); push(2, 16'hA002); push(2, 16'hA003);
    auto_done = 0;
    release_reset();
    while ((!sent || busy_o || RX_ACK) && n < 200) begin
      tick();
      n++;
      if (!sent && rxc[2] == 3 && RX_ACK) begin
        pkt_done_i = 1'b1;
        sent = 1;
      end
    end
    tests++;
    if (n >= 200 || rxc[2] != 3) begin
      fails++;
      $display("FAIL packet_words: got %0d words expected 3", rxc[2]);
    end
    tests++;
    if (idle_cyc <= ack_fall_cyc) begin
      fails++;
      $display("FAIL packet_drain: idle at cycle %0d, final ACK fell at %0d", idle_cyc, ack_fall_cyc);
    end
    check_seq("packet", '{2, 0, 0, 0}, '{3, 0, 0, 0}, 1);
  endtask
  task automatic test_fairness();
    hold_reset();
    for (int k = 1; k <= 10; k++) push(0, 16'hE000 + 16'(k));
    push(1, 16'h5001); push(1, 16'h5002);
    release_reset();
    run_until_idle("fairness", 800);
    check_seq("fairness", '{0, 1, 0, 0}, '{4, 2, 4, 2}, 4);
  endtask
  task automatic test_timeout();
    int n = 0, hi = 0;
    bit seen = 0;
    hold_reset();
    push(3, 16'h3001); push(0, 16'h0E01);
    ds_en = 0;
    release_reset();
    while (!seen && n < 100) begin
      tick();
      n++;
      if (timeout_o) seen = 1;
      else if (RX_REQ) hi++;
    end
    tests++;
    if (!seen || hi != TO) begin
      fails++;
      $display("FAIL timeout_latency: seen=%0d after %0d REQ cycles expected %0d", seen, hi, TO);
    end
    tests++;
    if (RX_REQ !== 1'b0 || busy_o !== 1'b0 || rx_ack_o !== 4'b0) begin
      fails++;
      $display("FAIL timeout_release: RX_REQ=%b busy=%b rx_ack_o=%b expected 0", RX_REQ, busy_o, rx_ack_o);
    end
    ds_en = 1;
    tick();
    tests++;
    if (timeout_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse: timeout_o=%b expected 0", timeout_o);
    end
    run_until_idle("timeout", 400);
    check_seq("timeout", '{3, 0, 3, 0}, '{0, 1, 1, 0}, 3);
    tests++;
    if (tmo_cnt != 1) begin
      fails++;
      $display("FAIL timeout_count: got %0d pulses expected 1", tmo_cnt);
    end
  endtask
  task automatic test_timeout_vs_done();
    int n = 0, hi = 0;
    bit seen = 0, sent = 0;
    hold_reset();
    push(2, 16'h2001); push(3, 16'h3001); push(1, 16'h1001);
    ds_en = 0;
    auto_done = 0;
    release_reset();
    while (!seen && n < 100) begin
      tick();
      n++;
      if (timeout_o) seen = 1;
      else if (RX_REQ) hi++;
      if (hi == TO && !sent) begin
        pkt_done_i = 1'b1;
        sent = 1;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL tmo_done_seen: no timeout after %0d cycles", n);
    end
    ds_en = 1;
    auto_done = 1;
    run_until_idle("tmo_done", 400);
    check_seq("tmo_done", '{2, 3, 1, 2}, '{0, 1, 1, 1}, 4);
    tests++;
    if (tmo_cnt != 1) begin
      fails++;
      $display("FAIL tmo_done_count: got %0d pulses expected 1", tmo_cnt);
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    hold_reset();
    push(1, 16'h1234);
    up_en[1] = 0;
    release_reset();
    while (!(RX_REQ === 1'b1 && rx_ack_o[1] === 1'b1) && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL mid_setup: RX_REQ=%b rx_ack_o=%b never both high", RX_REQ, rx_ack_o);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({rx_ack_o, RX_REQ, RX_DATA, grant_dir_o, busy_o, timeout_o} !== 25'b0) begin
      fails++;
      $display("FAIL mid_reset: ack=%b req=%b data=%h dir=%0d busy=%b tmo=%b expected 0",
               rx_ack_o, RX_REQ, RX_DATA, grant_dir_o, busy_o, timeout_o);
    end
    clear_bench();
    for (int i = 0; i < 4; i++) push(i, 16'($urandom));
    release_reset();
    run_until_idle("mid_reset", 400);
    check_seq("mid_reset", '{2, 3, 0, 1}, '{1, 1, 1, 1}, 4);
  endtask
  task automatic test_random();
    int total, got;
    for (int it = 0; it < 6; it++) begin
      hold_reset();
      total = 0;
      for (int i = 0; i < 4; i++) begin
        int n = $urandom_range(0, 7);
        for (int k = 0; k < n; k++) push(i, 16'($urandom));
        total += n;
      end
      release_reset();
      run_until_idle("random", 2000);
      got = 0;
      foreach (gwords[k]) got += gwords[k];
      tests++;
      if (got != total) begin
        fails++;
        $display("FAIL random_total[%0d]: got %0d words expected %0d", it, got, total);
      end
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_rr_order();
    test_packet();
    test_fairness();
    test_timeout();
    test_timeout_vs_done();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
